bimodal_ctrl: RTL and testbench

Controller for the 512-entry, 2-bit bimodal prediction table used by the branch predictor front end. It owns the table's single RAM port and handles three jobs on that port. First, it clears the table after reset. Second, it serves lookup reads from the fetch-side predecoder. Third, it applies buffered outcome updates as read-modify-write (RMW) cycles on the saturating counters. It sits between the predecoder/fetch logic (lookup and update requesters) and an external synchronous single-port RAM.

---
 rtl/bimodal_ctrl.sv | 147 ++++++++++++++
 tb/tb_bimodal_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bimodal_ctrl.sv
// Owner of the single RAM port behind the 2-bit bimodal prediction table:
// post-reset table clear, 1-cycle lookups, and queued saturating-counter RMW updates.
module bimodal_ctrl #(
  parameter int         IDX_W      = 9,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_VAL   = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lu_valid,
  input  logic [IDX_W-1:0] lu_index,
  output logic             lu_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [1:0]       pred_counter,
  input  logic             up_valid,
  input  logic [IDX_W-1:0] up_index,
  input  logic             up_taken,
  output logic             up_ready,
  output logic             init_done,
  output logic [IDX_W-1:0] ram_addr,
  output logic             ram_we,
  output logic [1:0]       ram_wdata,
  input  logic [1:0]       ram_rdata
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W:0]   INIT_LAST = {1'b0, {IDX_W{1'b1}}};

  typedef enum logic [1:0] {INIT, IDLE, UPD_RD, UPD_WR} state_t;

  state_t           state, state_nxt;
  logic [IDX_W:0]   init_cnt;
  logic             init_done_r;
  logic [IDX_W-1:0] fifo_idx [FIFO_DEPTH];
  logic             fifo_tkn [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full, fifo_empty;
  logic             push, pop, lu_acc;
  logic [IDX_W-1:0] upd_idx_p1;
  logic             upd_tkn_p1;
  logic             pred_vld_p1;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    else       return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
  endfunction

  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);
  assign up_ready   = init_done_r && !fifo_full;
  assign push       = up_valid && up_ready;
  assign init_done  = init_done_r;

  always_comb begin
    state_nxt = state;
    lu_ready  = 1'b0;
    lu_acc    = 1'b0;
    pop       = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = 2'b00;
    case (state)
      INIT: begin
        ram_addr  = init_cnt[IDX_W-1:0];
        ram_we    = 1'b1;
        ram_wdata = INIT_VAL;
        if (init_cnt == INIT_LAST) state_nxt = IDLE;
      end
      IDLE: begin
        lu_ready = !fifo_full;
        if (fifo_full) begin
          state_nxt = UPD_RD;
          pop       = 1'b1;
        end else if (lu_valid) begin
          ram_addr = lu_index;
          lu_acc   = 1'b1;
        end else if (!fifo_empty) begin
          state_nxt = UPD_RD;
          pop       = 1'b1;
        end
      end
      UPD_RD: begin
        ram_addr  = upd_idx_p1;
        state_nxt = UPD_WR;
      end
      UPD_WR: begin
        ram_addr  = upd_idx_p1;
        ram_we    = 1'b1;
        ram_wdata = sat_update(ram_rdata, upd_tkn_p1);
        state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
    // Keep the RAM port quiet while reset is held, so no stray INIT write lands.
    if (reset) begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = 2'b00;
    end
  end

  // p0 -> p1: control state, FIFO bookkeeping, lookup valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= INIT;
      init_cnt    <= '0;
      init_done_r <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      pred_vld_p1 <= 1'b0;
    end else begin
      state       <= state_nxt;
      pred_vld_p1 <= lu_acc;
      if (state == INIT) init_cnt <= init_cnt + (IDX_W+1)'(1);
      if (state == INIT && state_nxt == IDLE) init_done_r <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // p0 -> p1: FIFO storage and the head entry latched for the RMW
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr] <= up_index;
      fifo_tkn[wr_ptr] <= up_taken;
    end
    if (pop) begin
      upd_idx_p1 <= fifo_idx[rd_ptr];
      upd_tkn_p1 <= fifo_tkn[rd_ptr];
    end
  end

  // The RAM output register supplies the prediction; only the valid is held here.
  assign pred_valid   = pred_vld_p1;
  assign pred_counter = pred_vld_p1 ? ram_rdata : 2'b00;
  assign pred_taken   = pred_counter[1];

endmodule

// File: tb/tb_bimodal_ctrl.sv
// Directed bench for bimodal_ctrl with a behavioural synchronous single-port RAM.
module tb_bimodal_ctrl;
  localparam int IDX_W = 9;
  localparam int DEPTH = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             lu_valid = 1'b0;
  logic [IDX_W-1:0] lu_index = '0;
  logic             lu_ready;
  logic             pred_valid, pred_taken;
  logic [1:0]       pred_counter;
  logic             up_valid = 1'b0;
  logic [IDX_W-1:0] up_index = '0;
  logic             up_taken = 1'b0;
  logic             up_ready, init_done;
  logic [IDX_W-1:0] ram_addr;
  logic             ram_we;
  logic [1:0]       ram_wdata;
  logic [1:0]       ram_rdata;

  logic [1:0] mem [DEPTH];
  logic       scribble = 1'b0;
  int         wlog [$];
  int         errors = 0;
  int         checks = 0;
  int         bad, base;

  bimodal_ctrl #(.IDX_W(IDX_W), .FIFO_DEPTH(4), .INIT_VAL(2'b01)) dut (
    .clk(clk), .reset(reset),
    .lu_valid(lu_valid), .lu_index(lu_index), .lu_ready(lu_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_counter(pred_counter),
    .up_valid(up_valid), .up_index(up_index), .up_taken(up_taken), .up_ready(up_ready),
    .init_done(init_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model; scribble fills the table with 2'b11 so a clear is observable.
  always @(posedge clk) begin
    if (scribble) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 2'b11;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
    if (ram_we && init_done) wlog.push_back(int'(ram_addr) * 4 + int'(ram_wdata));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic reset_and_scribble();
    reset = 1'b1;
    lu_valid = 1'b0;
    up_valid = 1'b0;
    scribble = 1'b1;
    tick();
    scribble = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic init_walk(input int n, output int nbad);
    nbad = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      if (!(ram_we === 1'b1 && ram_addr === IDX_W'(i) && ram_wdata === 2'b01 &&
            lu_ready === 1'b0 && up_ready === 1'b0 && init_done === 1'b0))
        nbad++;
      tick();
    end
  endtask

  task automatic full_init(input string tag);
    int nb;
    int mbad;
    init_walk(DEPTH, nb);
    chk({tag, "_sweep"}, 32'(nb), 32'd0);
    #1;
    chk({tag, "_done"}, 32'(init_done), 32'd1);
    mbad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== 2'b01) mbad++;
    chk({tag, "_mem"}, 32'(mbad), 32'd0);
  endtask

  task automatic lookup(input string tag, input int idx, input logic [1:0] exp);
    lu_valid = 1'b1;
    lu_index = IDX_W'(idx);
    #1;
    chk({tag, "_lu_ready"}, 32'(lu_ready), 32'd1);
    tick();
    lu_valid = 1'b0;
    #1;
    chk({tag, "_pred_valid"}, 32'(pred_valid), 32'd1);
    chk({tag, "_pred_counter"}, 32'(pred_counter), 32'(exp));
    chk({tag, "_pred_taken"}, 32'(pred_taken), 32'(exp[1]));
    tick();
  endtask

  task automatic apply_update(input int idx, input logic tkn);
    up_valid = 1'b1;
    up_index = IDX_W'(idx);
    up_taken = tkn;
    tick();
    up_valid = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    logic [1:0] exp_t [3];
    logic [1:0] exp_n [3];
    int         exp_log [5];
    exp_t = '{2'd2, 2'd3, 2'd3};
    exp_n = '{2'd2, 2'd1, 2'd0};

    // Reset values and first table clear
    reset = 1'b1;
    scribble = 1'b1;
    tick();
    scribble = 1'b0;
    tick();
    #1;
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_lu_ready", 32'(lu_ready), 32'd0);
    chk("rst_up_ready", 32'(up_ready), 32'd0);
    chk("rst_pred_valid", 32'(pred_valid), 32'd0);
    chk("rst_pred_taken", 32'(pred_taken), 32'd0);
    chk("rst_pred_counter", 32'(pred_counter), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    reset = 1'b0;
    full_init("init0");
    chk("idle_lu_ready", 32'(lu_ready), 32'd1);
    chk("idle_up_ready", 32'(up_ready), 32'd1);
    chk("idle_ram_we", 32'(ram_we), 32'd0);
    tick();

    // Plain lookup after clear
    lookup("lu5", 5, 2'b01);
    #1;
    chk("lu5_pred_drop", 32'(pred_valid), 32'd0);
    tick();

    // Saturating counter up then down
    for (int k = 0; k < 3; k++) begin
      apply_update(5, 1'b1);
      lookup($sformatf("tk%0d", k), 5, exp_t[k]);
    end
    for (int k = 0; k < 3; k++) begin
      apply_update(5, 1'b0);
      lookup($sformatf("nt%0d", k), 5, exp_n[k]);
    end

    // Back-pressure: lookups every cycle while four updates fill the FIFO
    base = wlog.size();
    lu_valid = 1'b1;
    lu_index = IDX_W'(7);
    for (int k = 0; k < 4; k++) begin
      up_valid = 1'b1;
      up_index = IDX_W'(10 + k);
      up_taken = 1'b1;
      #1;
      chk($sformatf("bp_up_ready%0d", k), 32'(up_ready), 32'd1);
      chk($sformatf("bp_lu_ready%0d", k), 32'(lu_ready), 32'd1);
      tick();
    end
    up_valid = 1'b0;
    #1;
    chk("bp_full_up_ready", 32'(up_ready), 32'd0);
    chk("bp_full_lu_ready", 32'(lu_ready), 32'd0);
    chk("bp_full_pred_valid", 32'(pred_valid), 32'd1);
    chk("bp_full_pred_counter", 32'(pred_counter), 32'd1);
    tick();
    #1;
    chk("bp_rd_lu_ready", 32'(lu_ready), 32'd0);
    chk("bp_rd_pred_valid", 32'(pred_valid), 32'd0);
    chk("bp_rd_up_ready", 32'(up_ready), 32'd1);
    tick();
    #1;
    chk("bp_wr_lu_ready", 32'(lu_ready), 32'd0);
    chk("bp_wr_ram_we", 32'(ram_we), 32'd1);
    chk("bp_wr_ram_addr", 32'(ram_addr), 32'd10);
    chk("bp_wr_ram_wdata", 32'(ram_wdata), 32'd2);
    tick();
    #1;
    chk("bp_resume_lu_ready", 32'(lu_ready), 32'd1);
    tick();
    lu_valid = 1'b0;
    #1;
    chk("bp_resume_pred_valid", 32'(pred_valid), 32'd1);
    repeat (12) tick();
    chk("bp_log_size", 32'(wlog.size() - base), 32'd4);
    for (int k = 0; k < 4; k++)
      if (base + k < wlog.size())
        chk($sformatf("bp_log%0d", k), 32'(wlog[base + k]), 32'((10 + k) * 4 + 2));

    // Push and pop in the same cycle at count 2, then fill to prove count stayed 2
    base = wlog.size();
    exp_log = '{20 * 4 + 2, 21 * 4 + 0, 22 * 4 + 2, 23 * 4 + 2, 24 * 4 + 0};
    lu_valid = 1'b1;
    lu_index = IDX_W'(0);
    up_valid = 1'b1; up_index = IDX_W'(20); up_taken = 1'b1;
    tick();
    up_index = IDX_W'(21); up_taken = 1'b0;
    tick();
    lu_valid = 1'b0;
    up_index = IDX_W'(22); up_taken = 1'b1;
    #1;
    chk("pp_same_up_ready", 32'(up_ready), 32'd1);
    tick();
    up_index = IDX_W'(23); up_taken = 1'b1;
    #1;
    chk("pp_rd_up_ready", 32'(up_ready), 32'd1);
    tick();
    up_index = IDX_W'(24); up_taken = 1'b0;
    #1;
    chk("pp_wr_up_ready", 32'(up_ready), 32'd1);
    tick();
    up_valid = 1'b0;
    #1;
    chk("pp_full_up_ready", 32'(up_ready), 32'd0);
    repeat (16) tick();
    chk("pp_log_size", 32'(wlog.size() - base), 32'd5);
    for (int k = 0; k < 5; k++)
      if (base + k < wlog.size())
        chk($sformatf("pp_log%0d", k), 32'(wlog[base + k]), 32'(exp_log[k]));

    // Reset with a lookup in flight
    lu_valid = 1'b1;
    lu_index = IDX_W'(5);
    tick();
    lu_valid = 1'b0;
    #1;
    chk("fl_pred_valid_pre", 32'(pred_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("fl_pred_valid_rst", 32'(pred_valid), 32'd0);
    chk("fl_ram_we_rst", 32'(ram_we), 32'd0);
    reset_and_scribble();
    full_init("init1");
    tick();

    // Reset during UPD_WR with a second update still queued
    lu_valid = 1'b1;
    lu_index = IDX_W'(0);
    up_valid = 1'b1; up_index = IDX_W'(30); up_taken = 1'b1;
    tick();
    up_index = IDX_W'(31);
    tick();
    up_valid = 1'b0;
    lu_valid = 1'b0;
    tick();
    tick();
    #1;
    chk("uw_ram_we", 32'(ram_we), 32'd1);
    chk("uw_ram_addr", 32'(ram_addr), 32'd30);
    reset = 1'b1;
    #1;
    chk("uw_rst_ram_we", 32'(ram_we), 32'd0);
    chk("uw_rst_init_done", 32'(init_done), 32'd0);
    chk("uw_rst_up_ready", 32'(up_ready), 32'd0);
    chk("uw_rst_pred_valid", 32'(pred_valid), 32'd0);
    reset_and_scribble();
    full_init("init2");
    base = wlog.size();
    repeat (10) tick();
    chk("uw_fifo_flushed", 32'(wlog.size() - base), 32'd0);
    lookup("uw_lu30", 30, 2'b01);
    lookup("uw_lu31", 31, 2'b01);

    // Reset during the address-200 clear write
    reset_and_scribble();
    init_walk(200, bad);
    chk("i200_partial_sweep", 32'(bad), 32'd0);
    #1;
    chk("i200_ram_addr", 32'(ram_addr), 32'd200);
    reset = 1'b1;
    #1;
    chk("i200_rst_ram_we", 32'(ram_we), 32'd0);
    chk("i200_rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("i200_rst_init_done", 32'(init_done), 32'd0);
    reset_and_scribble();
    full_init("init3");
    tick();
    lookup("i200_lu200", 200, 2'b01);
    lookup("i200_lu511", 511, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
